// File: rtl/instruction_fetch.sv
// Fetch stage of the single-issue MIPS pipeline: owns the PC, drives the
// instruction memory address and fills the IF/ID register with stall/redirect/halt handling.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [32:0] MEM_BYTES = 33'd64
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] pc,
  input  logic [31:0] instruction,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] ifid_instr_reg, ifid_instr_next;
  logic [31:0] ifid_pc4_reg, ifid_pc4_next;
  logic        ifid_valid_reg, ifid_valid_next;
  logic [31:0] count_reg, count_next;

  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;
  logic        pc_in_range;

  assign redirect    = jump | branch_taken;
  assign pc_plus4    = pc_reg + 32'd4;
  assign pc_in_range = ({1'b0, pc_reg} < MEM_BYTES);

  // Jump region comes from the PC+4 of the jump itself, which sits in IF/ID.
  always_comb begin
    if (jump) begin
      redirect_target = {ifid_pc4_reg[31:28], jump_index, 2'b00};
    end else begin
      redirect_target = branch_target & 32'hFFFF_FFFC;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= RUN;
      pc_reg         <= RESET_PC;
      ifid_instr_reg <= 32'd0;
      ifid_pc4_reg   <= 32'd0;
      ifid_valid_reg <= 1'b0;
      count_reg      <= 32'd0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      ifid_instr_reg <= ifid_instr_next;
      ifid_pc4_reg   <= ifid_pc4_next;
      ifid_valid_reg <= ifid_valid_next;
      count_reg      <= count_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    ifid_instr_next = ifid_instr_reg;
    ifid_pc4_next   = ifid_pc4_reg;
    ifid_valid_next = ifid_valid_reg;
    count_next      = count_reg;

    if (redirect) begin
      // No delay slots: the wrong-path word is dropped as a bubble.
      state_next      = RUN;
      pc_next         = redirect_target;
      ifid_instr_next = 32'd0;
      ifid_pc4_next   = 32'd0;
      ifid_valid_next = 1'b0;
    end else if (!stall) begin
      case (state_reg)
        RUN: begin
          if (pc_in_range) begin
            pc_next         = pc_plus4;
            ifid_instr_next = instruction;
            ifid_pc4_next   = pc_plus4;
            ifid_valid_next = 1'b1;
            count_next      = count_reg + 32'd1;
          end else begin
            state_next      = HALT;
            ifid_instr_next = 32'd0;
            ifid_pc4_next   = 32'd0;
            ifid_valid_next = 1'b0;
          end
        end
        HALT: begin
          ifid_instr_next = 32'd0;
          ifid_pc4_next   = 32'd0;
          ifid_valid_next = 1'b0;
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  assign pc                = pc_reg;
  assign if_id_instruction = ifid_instr_reg;
  assign if_id_pc_plus4    = ifid_pc4_reg;
  assign if_id_valid       = ifid_valid_reg;
  assign halted            = (state_reg == HALT);
  assign fetch_count       = count_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed plan plus randomized stall/redirect/reset
// traffic against a behavioural PC/IF-ID model; a second instance covers jump regions.
module tb_instruction_fetch;

  localparam int MEM_WORDS = 16;  // 64 bytes
  localparam logic [31:0] OOR_WORD = 32'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc, instruction;
  logic        stall, branch_taken, jump;
  logic [31:0] branch_target;
  logic [25:0] jump_index;
  logic [31:0] if_id_instruction, if_id_pc_plus4, fetch_count;
  logic        if_id_valid, halted;

  // Second instance placed high in the address space to exercise the jump region bits.
  logic        w_reset, w_stall, w_branch_taken, w_jump;
  logic [31:0] w_pc, w_instruction, w_branch_target;
  logic [25:0] w_jump_index;
  logic [31:0] w_if_id_instruction, w_if_id_pc_plus4, w_fetch_count;
  logic        w_if_id_valid, w_halted;

  logic [31:0] mem [MEM_WORDS];

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  logic [31:0] m_pc, m_ifi, m_ifp, m_cnt;
  logic        m_ifv, m_halt;

  always #5 clock = ~clock;

  assign instruction   = (pc < 32'd64) ? mem[pc[5:2]] : OOR_WORD;
  assign w_instruction = 32'h1234_5678 ^ w_pc;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .MEM_BYTES(33'd64)) dut (
    .clock(clock), .reset(reset), .pc(pc), .instruction(instruction),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index),
    .if_id_instruction(if_id_instruction), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid), .halted(halted), .fetch_count(fetch_count)
  );

  instruction_fetch #(.RESET_PC(32'hA000_0000), .MEM_BYTES(33'h1_0000_0000)) dut_wide (
    .clock(clock), .reset(w_reset), .pc(w_pc), .instruction(w_instruction),
    .stall(w_stall), .branch_taken(w_branch_taken), .branch_target(w_branch_target),
    .jump(w_jump), .jump_index(w_jump_index),
    .if_id_instruction(w_if_id_instruction), .if_id_pc_plus4(w_if_id_pc_plus4),
    .if_id_valid(w_if_id_valid), .halted(w_halted), .fetch_count(w_fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_ifi = 32'd0; m_ifp = 32'd0; m_ifv = 1'b0; m_cnt = 32'd0; m_halt = 1'b0;
  endtask

  // One clock edge of the fetch stage, from the priority rules.
  task automatic model_edge(input logic s, input logic b, input logic [31:0] bt,
                            input logic j, input logic [25:0] ji);
    logic [31:0] word;
    word = (m_pc < 32'd64) ? mem[m_pc / 4] : OOR_WORD;
    if (j || b) begin
      m_pc = j ? {m_ifp[31:28], ji, 2'b00} : (bt / 4) * 4;
      m_ifi = 0; m_ifp = 0; m_ifv = 0; m_halt = 0;
    end else if (s) begin
      // everything holds
    end else if (m_halt || m_pc >= 32'd64) begin
      m_halt = 1; m_ifi = 0; m_ifp = 0; m_ifv = 0;
    end else begin
      m_ifi = word; m_ifp = m_pc + 4; m_ifv = 1; m_pc = m_pc + 4; m_cnt = m_cnt + 1;
    end
  endtask

  task automatic check_model();
    check("pc", pc, m_pc);
    check("if_id_instruction", if_id_instruction, m_ifi);
    check("if_id_pc_plus4", if_id_pc_plus4, m_ifp);
    check("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_ifv});
    check("halted", {31'd0, halted}, {31'd0, m_halt});
    check("fetch_count", fetch_count, m_cnt);
  endtask

  // Drive one cycle's inputs, clock it, then compare just after the edge.
  task automatic step(input logic s, input logic b, input logic [31:0] bt,
                      input logic j, input logic [25:0] ji);
    stall = s; branch_taken = b; branch_target = bt; jump = j; jump_index = ji;
    model_edge(s, b, bt, j, ji);
    @(posedge clock);
    #1;
    $display("t=%0t s=%0b b=%0b bt=%h j=%0b ji=%h -> pc=%h v=%0b p4=%h h=%0b cnt=%0d",
             $time, s, b, bt, j, ji, pc, if_id_valid, if_id_pc_plus4, halted, fetch_count);
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
  endtask

  // Called 1 time unit after an edge: assert reset between edges, release before the next.
  task automatic async_reset();
    #3 reset = 1'b0;
    #1;
    model_reset();
    check("rst_pc", pc, 32'd0);
    check("rst_instr", if_id_instruction, 32'd0);
    check("rst_pc4", if_id_pc_plus4, 32'd0);
    check("rst_valid", {31'd0, if_id_valid}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_count", fetch_count, 32'd0);
    #2 reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    reset = 1'b0; stall = 0; branch_taken = 0; branch_target = 0; jump = 0; jump_index = 0;
    w_reset = 1'b0; w_stall = 0; w_branch_taken = 0; w_branch_target = 0; w_jump = 0; w_jump_index = 0;
    model_reset();
    @(posedge clock);
    @(posedge clock);
    #1;
    check_model();
    #2 reset = 1'b1;

    // free run, then a two-cycle stall at pc=8
    idle(2);
    check("pc_before_stall", pc, 32'd8);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("pc_during_stall", pc, 32'd8);
    check("count_during_stall", fetch_count, 32'd2);
    idle(1);
    check("pc_after_stall", pc, 32'd12);
    check("count_3", fetch_count, 32'd3);

    // branch with a simultaneous stall: redirect wins, target aligned down
    step(1, 1, 32'h0000_0011, 0, 0);
    check("br_pc", pc, 32'h10);
    check("br_bubble", {31'd0, if_id_valid}, 32'd0);
    idle(1);
    check("br_pc4", if_id_pc_plus4, 32'h14);
    check("br_word", if_id_instruction, mem[4]);

    // jump wins over branch; low region target
    step(0, 1, 32'h0000_0030, 1, 26'h000_0005);
    check("jmp_pc", pc, 32'h14);

    // run off the end of memory
    async_reset();
    idle(16);
    check("pc_64", pc, 32'd64);
    check("count_16", fetch_count, 32'd16);
    idle(2);
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_pc", pc, 32'd64);
    check("halt_valid", {31'd0, if_id_valid}, 32'd0);
    check("halt_count", fetch_count, 32'd16);
    step(0, 1, 32'd0, 0, 0);
    check("unhalt", {31'd0, halted}, 32'd0);
    check("unhalt_pc", pc, 32'd0);

    // async reset while pc=20
    async_reset();
    idle(5);
    check("pc_20", pc, 32'd20);
    async_reset();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      int r;
      logic s, b, j;
      logic [31:0] bt;
      logic [25:0] ji;
      r  = $urandom_range(0, 99);
      j  = (r < 4);
      b  = (r >= 4 && r < 14) || ($urandom_range(0, 9) == 0 && r < 20);
      s  = ($urandom_range(0, 4) == 0);
      bt = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 90));
      ji = ($urandom_range(0, 7) == 0) ? 26'($urandom) : 26'($urandom_range(0, 20));
      step(s, b, bt, j, ji);
      if ($urandom_range(0, 99) == 0) async_reset();
    end
    stall = 0; branch_taken = 0; jump = 0;

    // high-region instance: jump keeps bits [31:28] of the jump's PC+4
    #3 w_reset = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    check("w_pc", w_pc, 32'hA000_0008);
    check("w_pc4", w_if_id_pc_plus4, 32'hA000_0008);
    check("w_word", w_if_id_instruction, 32'h1234_5678 ^ 32'hA000_0004);
    w_jump = 1'b1; w_jump_index = 26'h000_0003;
    @(posedge clock); #1;
    w_jump = 1'b0;
    check("w_jmp_pc", w_pc, 32'hA000_000C);
    check("w_jmp_bubble", {31'd0, w_if_id_valid}, 32'd0);
    check("w_jmp_count", w_fetch_count, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
